prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Top-level run controller for the 9-bit-instruction processor datapath. Accepts a program-run request, holds the datapath in init for a fixed number of cycles, and decodes `opcode`/`fcode` into the registered-state-gated `CTRL_*` strobes while running. It detects halt and drives a done handshake with a cycle count back to the testbench or host. It sits directly above `datapath`, driving its `START` and all `CTRL_*` inputs and consuming its `opcode`, `fcode` and `DONE`.

## Interface
Parameters:
- `INIT_CYCLES`, 2 — cycles `START` is held high before the first fetch (1..15).
- `MAX_CYCLES`, 16'hFFFF — watchdog limit on RUN cycles; only used with `SEQ_WATCHDOG_EN`.

Ports:
- `CLK`  in  1  — system clock.
- `reset`  in  1  — synchronous, active-high.
- `start_req`  in  1  — one-cycle request to run the program; honoured only in IDLE or FINISHED.
- `opcode`  in  4  — from datapath.
- `fcode`  in  1  — from datapath.
- `dp_done`  in  1  — datapath `DONE`.
- `START`  out  1  — to datapath init/reset.
- `CTRL_branch_rel_nz`, `CTRL_branch_rel_z`, `CTRL_branch_abs`, `CTRL_reg_write_en`, `CTRL_reg_sel`, `CTRL_lut_in`, `CTRL_mem_to_reg`, `CTRL_alu_src`, `CTRL_alu_sc_in`, `CTRL_read_mem`, `CTRL_write_mem`  out  1 each — datapath strobes.
- `CTRL_alu_op`  out  3  — ALU operation.
- `busy`  out  1  — high in INIT and RUN.
- `run_done`  out  1  — level; high in FINISHED.
- `timeout`  out  1  — FINISHED was reached by the watchdog.
- `cycle_count`  out  16  — RUN cycles of the last or current run.

## Operation
- States: IDLE, INIT, RUN, FINISHED.
- IDLE/FINISHED + `start_req` → INIT. Clear `cycle_count`, `timeout` and the init counter.
- INIT: `START`=1. After `INIT_CYCLES` cycles → RUN.
- RUN: decode is combinational from `opcode`/`fcode`. Every `CTRL_*` output is forced to 0 outside RUN.
- Decode (opcode: asserted strobes; unlisted strobes are 0):
  - 0–4 ADD/SUB/AND/OR/XOR: `reg_write_en`, `alu_op`=0..4.
  - 5 SHL / 6 SHR: `reg_write_en`, `alu_op`=5/6, `alu_sc_in`=`fcode`.
  - 7 ADDI: `reg_write_en`, `alu_src`, `alu_op`=0.
  - 8 LD: `read_mem`, `mem_to_reg`, `reg_write_en`.
  - 9 ST: `write_mem`.
  - 10 BZ: `branch_rel_z`, `alu_op`=1.
  - 11 BNZ: `branch_rel_nz`, `alu_op`=1.
  - 12 JMP: `branch_abs`.
  - 13 JR: `branch_abs`, `lut_in`.
  - 14 CALL: `reg_sel`, `reg_write_en`.
  - 15: `fcode`=0 is NOP (all 0); `fcode`=1 is HALT.
- RUN exits to FINISHED on HALT decode or `dp_done`=1. On the HALT cycle itself all strobes are 0.
- `cycle_count` increments every RUN cycle, including the exiting cycle, and saturates at 16'hFFFF.
- `start_req` in INIT or RUN is ignored.

## Timing
- Reset: state IDLE, `START`=1, all `CTRL_*`=0, `busy`=0, `run_done`=0, `timeout`=0, `cycle_count`=0. `START` is held high in IDLE so the datapath stays initialised.
- `start_req` at edge n → INIT visible after edge n. `START` stays high through INIT and drops on the first RUN cycle, which is cycle n+1+`INIT_CYCLES`.
- Strobes are valid in the same cycle as `opcode`. There is no added pipeline latency.
- HALT or `dp_done` seen in RUN at edge m → `run_done`=1 and `busy`=0 from edge m+1 onward.
- `reset` has priority over all events, including mid-RUN. Outputs return to reset values at the next edge.
- `start_req` together with HALT in the same RUN cycle: halt wins and the request is dropped.

## Configuration
- `SEQ_WATCHDOG_EN` defined: in RUN, when `cycle_count` reaches `MAX_CYCLES`, the FSM goes to FINISHED with `timeout`=1 on the next edge.
- `SEQ_WATCHDOG_EN` undefined: no watchdog logic, `timeout` is tied to 0, and RUN lasts until HALT or `dp_done`.

## Test plan
- Reset, then `start_req` with `INIT_CYCLES`=2 → `START` high 2 cycles after IDLE exit, then `busy`=1 and `START`=0.
- RUN with opcode 8 → `read_mem`=`mem_to_reg`=`reg_write_en`=1 and all other strobes 0. Opcode 9 → `write_mem` only.
- 10 RUN cycles, then opcode 15 with `fcode`=1 → `run_done`=1 the next cycle, `cycle_count`=11, all strobes 0 during the HALT cycle.
- `reset` asserted on the 5th RUN cycle → next cycle IDLE, `cycle_count`=0, `START`=1.
- `SEQ_WATCHDOG_EN` with `MAX_CYCLES`=20 and opcode held at 0 → FINISHED, `timeout`=1, `cycle_count`=20. Without the macro, still RUN at cycle 100.
- FINISHED, then `start_req` → new run with `cycle_count` cleared and `run_done`=0.

Source files
------------

// File: rtl/prog_sequencer.sv
// Run controller for the 9-bit-instruction datapath: IDLE -> INIT -> RUN -> FINISHED.
// Optional watchdog on RUN length is enabled by defining SEQ_WATCHDOG_EN.
module prog_sequencer #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start_req,
  input  logic [3:0]  opcode,
  input  logic        fcode,
  input  logic        dp_done,
  output logic        START,
  output logic        CTRL_branch_rel_nz,
  output logic        CTRL_branch_rel_z,
  output logic        CTRL_branch_abs,
  output logic        CTRL_reg_write_en,
  output logic        CTRL_reg_sel,
  output logic        CTRL_lut_in,
  output logic        CTRL_mem_to_reg,
  output logic        CTRL_alu_src,
  output logic        CTRL_alu_sc_in,
  output logic        CTRL_read_mem,
  output logic        CTRL_write_mem,
  output logic [2:0]  CTRL_alu_op,
  output logic        busy,
  output logic        run_done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StFinished} state_e;

  localparam logic [3:0] InitLast = 4'(INIT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  init_cnt_q;
  logic        start_q;
  logic        busy_q;
  logic        run_done_q;
  logic        timeout_q;
  logic [15:0] cycle_count_q;

  logic        run_active;
  logic        halt;
  logic        wd_hit;
  logic [15:0] cycle_count_inc;

  assign run_active      = (state_q == StRun);
  assign halt            = run_active && (opcode == 4'd15) && fcode;
  assign cycle_count_inc = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;

`ifdef SEQ_WATCHDOG_EN
  // Fire on the cycle whose increment brings the count up to the limit.
  assign wd_hit = ({1'b0, cycle_count_q} + 17'd1) >= {1'b0, MAX_CYCLES};
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign wd_hit            = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q       <= StIdle;
      init_cnt_q    <= 4'd0;
      start_q       <= 1'b1;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      case (state_q)
        StIdle, StFinished: begin
          if (start_req) begin
            state_q       <= StInit;
            init_cnt_q    <= 4'd0;
            start_q       <= 1'b1;
            busy_q        <= 1'b1;
            run_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= 16'd0;
          end
        end
        StInit: begin
          if (init_cnt_q == InitLast) begin
            state_q <= StRun;
            start_q <= 1'b0;
          end else begin
            init_cnt_q <= init_cnt_q + 4'd1;
          end
        end
        StRun: begin
          cycle_count_q <= cycle_count_inc;
          // HALT and dp_done take precedence over the watchdog.
          if (halt || dp_done) begin
            state_q    <= StFinished;
            busy_q     <= 1'b0;
            run_done_q <= 1'b1;
          end else if (wd_hit) begin
            state_q    <= StFinished;
            busy_q     <= 1'b0;
            run_done_q <= 1'b1;
            timeout_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    CTRL_branch_rel_nz = 1'b0;
    CTRL_branch_rel_z  = 1'b0;
    CTRL_branch_abs    = 1'b0;
    CTRL_reg_write_en  = 1'b0;
    CTRL_reg_sel       = 1'b0;
    CTRL_lut_in        = 1'b0;
    CTRL_mem_to_reg    = 1'b0;
    CTRL_alu_src       = 1'b0;
    CTRL_alu_sc_in     = 1'b0;
    CTRL_read_mem      = 1'b0;
    CTRL_write_mem     = 1'b0;
    CTRL_alu_op        = 3'd0;
    if (run_active) begin
      unique case (opcode)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
          CTRL_reg_write_en = 1'b1;
          CTRL_alu_op       = opcode[2:0];
        end
        4'd5, 4'd6: begin
          CTRL_reg_write_en = 1'b1;
          CTRL_alu_op       = opcode[2:0];
          CTRL_alu_sc_in    = fcode;
        end
        4'd7: begin
          CTRL_reg_write_en = 1'b1;
          CTRL_alu_src      = 1'b1;
        end
        4'd8: begin
          CTRL_read_mem     = 1'b1;
          CTRL_mem_to_reg   = 1'b1;
          CTRL_reg_write_en = 1'b1;
        end
        4'd9:  CTRL_write_mem = 1'b1;
        4'd10: begin
          CTRL_branch_rel_z = 1'b1;
          CTRL_alu_op       = 3'd1;
        end
        4'd11: begin
          CTRL_branch_rel_nz = 1'b1;
          CTRL_alu_op        = 3'd1;
        end
        4'd12: CTRL_branch_abs = 1'b1;
        4'd13: begin
          CTRL_branch_abs = 1'b1;
          CTRL_lut_in     = 1'b1;
        end
        4'd14: begin
          CTRL_reg_sel      = 1'b1;
          CTRL_reg_write_en = 1'b1;
        end
        default: ;  // NOP and HALT drive no strobes
      endcase
    end
  end

  assign START       = start_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer against a cycle-level behavioural model.
// The model also follows SEQ_WATCHDOG_EN when that macro is defined for the build.
module tb_prog_sequencer;

  localparam int unsigned InitCycles = 2;
  localparam logic [15:0] MaxCycles  = 16'd20;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start_req;
  logic [3:0]  opcode;
  logic        fcode;
  logic        dp_done;
  logic        START;
  logic        CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en;
  logic        CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in;
  logic        CTRL_read_mem, CTRL_write_mem;
  logic [2:0]  CTRL_alu_op;
  logic        busy, run_done, timeout;
  logic [15:0] cycle_count;
  logic [13:0] dut_ctrl;

  always #5 CLK = ~CLK;

  prog_sequencer #(
    .INIT_CYCLES(InitCycles),
    .MAX_CYCLES (MaxCycles)
  ) dut (
    .CLK               (CLK),
    .reset             (reset),
    .start_req         (start_req),
    .opcode            (opcode),
    .fcode             (fcode),
    .dp_done           (dp_done),
    .START             (START),
    .CTRL_branch_rel_nz(CTRL_branch_rel_nz),
    .CTRL_branch_rel_z (CTRL_branch_rel_z),
    .CTRL_branch_abs   (CTRL_branch_abs),
    .CTRL_reg_write_en (CTRL_reg_write_en),
    .CTRL_reg_sel      (CTRL_reg_sel),
    .CTRL_lut_in       (CTRL_lut_in),
    .CTRL_mem_to_reg   (CTRL_mem_to_reg),
    .CTRL_alu_src      (CTRL_alu_src),
    .CTRL_alu_sc_in    (CTRL_alu_sc_in),
    .CTRL_read_mem     (CTRL_read_mem),
    .CTRL_write_mem    (CTRL_write_mem),
    .CTRL_alu_op       (CTRL_alu_op),
    .busy              (busy),
    .run_done          (run_done),
    .timeout           (timeout),
    .cycle_count       (cycle_count)
  );

  assign dut_ctrl = {CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
                     CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
                     CTRL_read_mem, CTRL_write_mem, CTRL_alu_op};

  int vectors;
  int miscompares;

  // Model: mode 0 idle, 1 init, 2 run, 3 finished.
  int m_mode;
  int m_init_left;
  int m_runs;
  bit m_timeout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe table: {bnz, bz, babs, rwe, rsel, lut, m2r, asrc, sc, rd, wr, aluop[2:0]}
  function automatic logic [13:0] ref_ctrl(input int md, input logic [3:0] op, input logic fc);
    logic [13:0] v;
    v = 14'd0;
    if (md == 2) begin
      case (op)
        4'd0:  v = 14'b00010000000_000;
        4'd1:  v = 14'b00010000000_001;
        4'd2:  v = 14'b00010000000_010;
        4'd3:  v = 14'b00010000000_011;
        4'd4:  v = 14'b00010000000_100;
        4'd5:  v = {8'b00010000, fc, 2'b00, 3'b101};
        4'd6:  v = {8'b00010000, fc, 2'b00, 3'b110};
        4'd7:  v = 14'b00010001000_000;
        4'd8:  v = 14'b00010010010_000;
        4'd9:  v = 14'b00000000001_000;
        4'd10: v = 14'b01000000000_001;
        4'd11: v = 14'b10000000000_001;
        4'd12: v = 14'b00100000000_000;
        4'd13: v = 14'b00100100000_000;
        4'd14: v = 14'b00011000000_000;
        default: v = 14'd0;
      endcase
    end
    return v;
  endfunction

  task automatic check_outputs();
    check("ctrl", dut_ctrl, ref_ctrl(m_mode, opcode, fcode));
    check("busy", busy, (m_mode == 1 || m_mode == 2));
    check("run_done", run_done, (m_mode == 3));
    check("timeout", timeout, m_timeout);
    check("cycle_count", cycle_count, m_runs);
    if (m_mode != 3) check("START", START, (m_mode == 0 || m_mode == 1));
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_init_left = 0;
    m_runs = 0;
    m_timeout = 1'b0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_mode == 0 || m_mode == 3) begin
      if (start_req) begin
        m_mode = 1;
        m_init_left = InitCycles;
        m_runs = 0;
        m_timeout = 1'b0;
      end
    end else if (m_mode == 1) begin
      m_init_left--;
      if (m_init_left == 0) m_mode = 2;
    end else begin
      if (m_runs < 65535) m_runs++;
      if ((opcode == 4'd15 && fcode) || dp_done) begin
        m_mode = 3;
      end
`ifdef SEQ_WATCHDOG_EN
      else if (m_runs >= int'(MaxCycles)) begin
        m_mode = 3;
        m_timeout = 1'b1;
      end
`endif
    end
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic cycle(input logic sr, input logic [3:0] op, input logic fc, input logic dd,
                       input logic rst);
    @(negedge CLK);
    start_req = sr;
    opcode    = op;
    fcode     = fc;
    dp_done   = dd;
    reset     = rst;
    #1;
    check_outputs();
    @(posedge CLK);
    model_step();
  endtask

  // Random instruction that is never HALT.
  task automatic run_op_no_halt();
    logic [3:0] op;
    logic       fc;
    op = 4'($urandom_range(0, 15));
    fc = (op == 4'd15) ? 1'b0 : 1'($urandom_range(0, 1));
    cycle(1'($urandom_range(0, 1)), op, fc, 1'b0, 1'b0);
  endtask

  task automatic idle_to_run();
    cycle(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < int'(InitCycles); i++) cycle(1'b1, 4'd15, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start_req = 1'b0;
    opcode = 4'd0;
    fcode = 1'b0;
    dp_done = 1'b0;
    repeat (3) @(posedge CLK);
    model_reset();

    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 4'd8, 1'b0, 1'b1, 1'b0);

    // Run: LD, ST, 8 more ops, then HALT with a simultaneous start request.
    idle_to_run();
    cycle(1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) run_op_no_halt();
    cycle(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    #1;
    check("halt_run_done", run_done, 1'b1);
    check("halt_count", cycle_count, 32'd11);
    cycle(1'b0, 4'd3, 1'b0, 1'b0, 1'b0);

    // Restart from FINISHED, then reset on the 5th RUN cycle.
    idle_to_run();
    for (int i = 0; i < 4; i++) run_op_no_halt();
    cycle(1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
    #1;
    check("rst_count", cycle_count, 32'd0);
    check("rst_START", START, 1'b1);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Long run with opcode 0 held: watchdog fires only when enabled.
    idle_to_run();
    for (int i = 0; i < 100; i++) cycle(1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    #1;
`ifdef SEQ_WATCHDOG_EN
    check("wd_timeout", timeout, 1'b1);
    check("wd_count", cycle_count, 32'd20);
`else
    check("nowd_busy", busy, 1'b1);
    check("nowd_count", cycle_count, 32'd100);
`endif
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
